// File: rtl/test_status_controller.sv
// test_status_controller: sequences DUT reset, counts run cycles and resolves a PASS/FAIL verdict
// from N masked success/failure channels. Optional heartbeat output via TEST_STATUS_HEARTBEAT_EN.
`default_nettype none

module test_status_controller #(
    parameter int NUM_CHANNELS = 4,
    parameter int CYCLE_W      = 64,
    parameter int RESET_CYCLES = 16,
    parameter int SUCCESS_MODE = 0
`ifdef TEST_STATUS_HEARTBEAT_EN
    ,
    parameter int HEARTBEAT_LOG2 = 10
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [CYCLE_W-1:0]      max_cycles,
    input  logic [NUM_CHANNELS-1:0] chan_mask,
    input  logic [NUM_CHANNELS-1:0] chan_success,
    input  logic [NUM_CHANNELS-1:0] chan_failure,
    output logic                    dut_reset,
    output logic                    running,
    output logic                    done,
    output logic                    passed,
    output logic [1:0]              fail_reason,
    output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] fail_channel,
    output logic [NUM_CHANNELS-1:0] success_seen,
    output logic [CYCLE_W-1:0]      cycle_count
`ifdef TEST_STATUS_HEARTBEAT_EN
    ,
    output logic                    heartbeat
`endif
);

    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    localparam logic [1:0] REASON_NONE    = 2'd0;
    localparam logic [1:0] REASON_TIMEOUT = 2'd1;
    localparam logic [1:0] REASON_CHANNEL = 2'd2;
    localparam logic [1:0] REASON_EMPTY   = 2'd3;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [HOLD_W-1:0]       hold_cnt, hold_next;
    logic [CYCLE_W-1:0]      max_lat, max_lat_next;
    logic [NUM_CHANNELS-1:0] mask, mask_next;
    logic                    dut_reset_next, running_next, done_next, passed_next;
    logic [1:0]              reason_next;
    logic [CH_W-1:0]         chan_next, low_fail_idx;
    logic [NUM_CHANNELS-1:0] seen_next, masked_fail, masked_succ;
    logic [CYCLE_W-1:0]      count_next;
    logic                    success_ok, timeout_hit;

    assign masked_fail = chan_failure & mask;
    assign masked_succ = chan_success & mask;

    // Mode 0 also counts successes arriving this cycle, so the last channel may complete the set
    assign success_ok = (SUCCESS_MODE == 0) ? (((success_seen | chan_success) & mask) == mask)
                                            : (|masked_succ);

    assign timeout_hit = (max_lat != '0) &&
                         (({1'b0, cycle_count} + (CYCLE_W+1)'(1)) >= {1'b0, max_lat});

    always_comb begin
        low_fail_idx = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (masked_fail[i]) begin
                low_fail_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_next     = state;
        hold_next      = hold_cnt;
        max_lat_next   = max_lat;
        mask_next      = mask;
        dut_reset_next = dut_reset;
        running_next   = running;
        done_next      = done;
        passed_next    = passed;
        reason_next    = fail_reason;
        chan_next      = fail_channel;
        seen_next      = success_seen;
        count_next     = cycle_count;
        case (state)
            HOLD: begin
                hold_next = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    max_lat_next = max_cycles;
                    mask_next    = chan_mask;
                    if (chan_mask == '0) begin
                        state_next  = FAIL;
                        done_next   = 1'b1;
                        reason_next = REASON_EMPTY;
                    end else begin
                        state_next     = RUN;
                        dut_reset_next = 1'b0;
                        running_next   = 1'b1;
                    end
                end
            end
            RUN: begin
                seen_next = success_seen | masked_succ;
                if (masked_fail != '0) begin
                    state_next  = FAIL;
                    reason_next = REASON_CHANNEL;
                    chan_next   = low_fail_idx;
                end else if (success_ok) begin
                    state_next  = PASS;
                    passed_next = 1'b1;
                    reason_next = REASON_NONE;
                end else if (timeout_hit) begin
                    state_next  = FAIL;
                    reason_next = REASON_TIMEOUT;
                end else if (cycle_count != '1) begin
                    count_next = cycle_count + 1'b1;
                end
                // Any verdict re-holds the DUT and freezes the counter
                if (state_next != RUN) begin
                    dut_reset_next = 1'b1;
                    running_next   = 1'b0;
                    done_next      = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            max_lat      <= '0;
            mask         <= '0;
            dut_reset    <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            passed       <= 1'b0;
            fail_reason  <= REASON_NONE;
            fail_channel <= '0;
            success_seen <= '0;
            cycle_count  <= '0;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_next;
            max_lat      <= max_lat_next;
            mask         <= mask_next;
            dut_reset    <= dut_reset_next;
            running      <= running_next;
            done         <= done_next;
            passed       <= passed_next;
            fail_reason  <= reason_next;
            fail_channel <= chan_next;
            success_seen <= seen_next;
            cycle_count  <= count_next;
        end
    end

`ifdef TEST_STATUS_HEARTBEAT_EN
    // Registered from next-state values so the pulse lines up with the displayed cycle_count
    logic heartbeat_next;
    assign heartbeat_next = (state_next == RUN) && (&count_next[HEARTBEAT_LOG2-1:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            heartbeat <= 1'b0;
        end else begin
            heartbeat <= heartbeat_next;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_test_status_controller.sv
// tb_test_status_controller: table-driven verdict scenarios plus directed reset/timeout/mode sequences.
`default_nettype none

module tb_test_status_controller;

    localparam int RC = 16;
    localparam logic [15:0] NONE = 16'hFFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] max_cycles = '0;
    logic [3:0]  chan_mask = '0;
    logic [3:0]  chan_success = '0;
    logic [3:0]  chan_failure = '0;

    logic        dut_reset, running, done, passed;
    logic [1:0]  fail_reason, fail_channel;
    logic [3:0]  success_seen;
    logic [63:0] cycle_count;

    logic        m1_dut_reset, m1_running, m1_done, m1_passed;
    logic [1:0]  m1_fail_reason, m1_fail_channel;
    logic [3:0]  m1_success_seen;
    logic [63:0] m1_cycle_count;
`ifdef TEST_STATUS_HEARTBEAT_EN
    logic        hb0, hb1;
`endif

    int tests = 0;
    int failed = 0;
    logic ran;

    always #5 clock = ~clock;

    test_status_controller #(
        .NUM_CHANNELS(4), .CYCLE_W(64), .RESET_CYCLES(RC), .SUCCESS_MODE(0)
`ifdef TEST_STATUS_HEARTBEAT_EN
        , .HEARTBEAT_LOG2(4)
`endif
    ) dut (
        .clock(clock), .reset(reset), .max_cycles(max_cycles), .chan_mask(chan_mask),
        .chan_success(chan_success), .chan_failure(chan_failure),
        .dut_reset(dut_reset), .running(running), .done(done), .passed(passed),
        .fail_reason(fail_reason), .fail_channel(fail_channel),
        .success_seen(success_seen), .cycle_count(cycle_count)
`ifdef TEST_STATUS_HEARTBEAT_EN
        , .heartbeat(hb0)
`endif
    );

    test_status_controller #(
        .NUM_CHANNELS(4), .CYCLE_W(64), .RESET_CYCLES(RC), .SUCCESS_MODE(1)
`ifdef TEST_STATUS_HEARTBEAT_EN
        , .HEARTBEAT_LOG2(4)
`endif
    ) dut_m1 (
        .clock(clock), .reset(reset), .max_cycles(max_cycles), .chan_mask(chan_mask),
        .chan_success(chan_success), .chan_failure(chan_failure),
        .dut_reset(m1_dut_reset), .running(m1_running), .done(m1_done), .passed(m1_passed),
        .fail_reason(m1_fail_reason), .fail_channel(m1_fail_channel),
        .success_seen(m1_success_seen), .cycle_count(m1_cycle_count)
`ifdef TEST_STATUS_HEARTBEAT_EN
        , .heartbeat(hb1)
`endif
    );

    typedef struct packed {
        logic [3:0]       mask;
        logic [15:0]      maxc;
        logic [3:0][15:0] s_cyc;
        logic [3:0][15:0] f_cyc;
        logic             ran;
        logic             passed;
        logic [1:0]       reason;
        logic [1:0]       chan;
        logic [15:0]      count;
        logic [3:0]       seen;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (running) ran = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        chan_success = '0;
        chan_failure = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        ran = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".dut_reset"}, 64'(dut_reset), 64'd1);
        chk({tag, ".running"}, 64'(running), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".passed"}, 64'(passed), 64'd0);
        chk({tag, ".reason"}, 64'(fail_reason), 64'd0);
        chk({tag, ".chan"}, 64'(fail_channel), 64'd0);
        chk({tag, ".seen"}, 64'(success_seen), 64'd0);
        chk({tag, ".count"}, cycle_count, 64'd0);
    endtask

    task automatic measure_hold(output int n);
        n = 0;
        while (dut_reset && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vec_t v;
        logic [63:0] frozen;

        //          mask     max      succ cycles (ch3..ch0)       fail cycles (ch3..ch0)        ran   pass  rsn   ch    count   seen
        vecs[0] = '{4'b1111, 16'd0,   {16'd9, 16'd7, 16'd5, 16'd3}, {4{NONE}},                   1'b1, 1'b1, 2'd0, 2'd0, 16'd9,  4'b1111};
        vecs[1] = '{4'b0101, 16'd100, {4{NONE}},                    {NONE, 16'd20, 16'd10, NONE}, 1'b1, 1'b0, 2'd2, 2'd2, 16'd20, 4'b0000};
        vecs[2] = '{4'b1111, 16'd50,  {4{NONE}},                    {4{NONE}},                   1'b1, 1'b0, 2'd1, 2'd0, 16'd49, 4'b0000};
        vecs[3] = '{4'b1001, 16'd0,   {NONE, NONE, NONE, 16'd5},    {16'd5, NONE, NONE, NONE},   1'b1, 1'b0, 2'd2, 2'd3, 16'd5,  4'b0001};
        vecs[4] = '{4'b0001, 16'd50,  {NONE, NONE, NONE, 16'd49},   {4{NONE}},                   1'b1, 1'b1, 2'd0, 2'd0, 16'd49, 4'b0001};
        vecs[5] = '{4'b0000, 16'd0,   {4{NONE}},                    {4{NONE}},                   1'b0, 1'b0, 2'd3, 2'd0, 16'd0,  4'b0000};
        vecs[6] = '{4'b0110, 16'd0,   {NONE, 16'd7, 16'd4, 16'd1},  {16'd3, NONE, NONE, 16'd2},  1'b1, 1'b1, 2'd0, 2'd0, 16'd7,  4'b0110};
        vecs[7] = '{4'b1111, 16'd0,   {4{NONE}},                    {16'd6, NONE, 16'd6, NONE},  1'b1, 1'b0, 2'd2, 2'd1, 16'd6,  4'b0000};
        vecs[8] = '{4'b0011, 16'd1,   {4{NONE}},                    {4{NONE}},                   1'b1, 1'b0, 2'd1, 2'd0, 16'd0,  4'b0000};
        vecs[9] = '{4'b0011, 16'd10,  {NONE, NONE, 16'd9, 16'd4},   {4{NONE}},                   1'b1, 1'b1, 2'd0, 2'd0, 16'd9,  4'b0011};

        // Reset values and exact DUT reset length
        do_reset();
        check_reset_vals("rst0");
        chan_mask = 4'b1111;
        max_cycles = 64'd0;
        measure_hold(n);
        chk("hold_len", 64'(n), 64'(RC));
        chk("hold_running", 64'(running), 64'd1);
        chk("hold_count0", cycle_count, 64'd0);

        for (int k = 0; k < 10; k++) begin
            v = vecs[k];
            chan_mask = v.mask;
            max_cycles = 64'(v.maxc);
            do_reset();
            repeat (RC) tick();
            for (int c = 0; c < 300 && !done; c++) begin
                for (int ch = 0; ch < 4; ch++) begin
                    chan_success[ch] = (v.s_cyc[ch] == 16'(c));
                    chan_failure[ch] = (v.f_cyc[ch] == 16'(c));
                end
                tick();
            end
            chan_success = '0;
            chan_failure = '0;
            chk($sformatf("v%0d.done", k), 64'(done), 64'd1);
            chk($sformatf("v%0d.ran", k), 64'(ran), 64'(v.ran));
            chk($sformatf("v%0d.passed", k), 64'(passed), 64'(v.passed));
            chk($sformatf("v%0d.reason", k), 64'(fail_reason), 64'(v.reason));
            chk($sformatf("v%0d.chan", k), 64'(fail_channel), 64'(v.chan));
            chk($sformatf("v%0d.count", k), cycle_count, 64'(v.count));
            chk($sformatf("v%0d.seen", k), 64'(success_seen), 64'(v.seen));
            chk($sformatf("v%0d.running", k), 64'(running), 64'd0);
            chk($sformatf("v%0d.dut_reset", k), 64'(dut_reset), 64'd1);
            // Terminal state must ignore further activity
            chan_success = 4'b1111;
            chan_failure = 4'b1111;
            repeat (3) tick();
            chan_success = '0;
            chan_failure = '0;
            chk($sformatf("v%0d.frz_count", k), cycle_count, 64'(v.count));
            chk($sformatf("v%0d.frz_reason", k), 64'(fail_reason), 64'(v.reason));
            chk($sformatf("v%0d.frz_passed", k), 64'(passed), 64'(v.passed));
            chk($sformatf("v%0d.frz_seen", k), 64'(success_seen), 64'(v.seen));
        end

        // No timeout and no events: stays in RUN
        chan_mask = 4'b1111;
        max_cycles = 64'd0;
        do_reset();
        repeat (RC) tick();
        for (int k = 0; k < 10000; k++) begin
`ifdef TEST_STATUS_HEARTBEAT_EN
            if (k < 64) chk($sformatf("hb@%0d", k), 64'(hb0), 64'((k % 16) == 15));
`endif
            tick();
        end
        chk("long.running", 64'(running), 64'd1);
        chk("long.done", 64'(done), 64'd0);
        chk("long.count", cycle_count, 64'd10000);

        // Reset in the middle of RUN restarts the hold sequence
        do_reset();
        repeat (RC) tick();
        repeat (30) tick();
        chk("mid.count", cycle_count, 64'd30);
        do_reset();
        check_reset_vals("mid_rst");
        measure_hold(n);
        chk("mid.hold_len", 64'(n), 64'(RC));

        // Reset after PASS
        chan_mask = 4'b0001;
        do_reset();
        repeat (RC) tick();
        chan_success = 4'b0001;
        tick();
        chan_success = '0;
        chk("pass0.passed", 64'(passed), 64'd1);
        chk("pass0.count", cycle_count, 64'd0);
        do_reset();
        check_reset_vals("pass_rst");
        measure_hold(n);
        chk("pass.hold_len", 64'(n), 64'(RC));

        // Any-success mode versus all-success mode on the same stimulus
        chan_mask = 4'b0110;
        max_cycles = 64'd0;
        do_reset();
        repeat (RC) tick();
        for (int c = 0; c <= 4; c++) begin
            chan_success = (c == 4) ? 4'b0010 : 4'b0000;
            tick();
        end
        chan_success = '0;
        chk("m1.done", 64'(m1_done), 64'd1);
        chk("m1.passed", 64'(m1_passed), 64'd1);
        chk("m1.count", m1_cycle_count, 64'd4);
        chk("m1.seen", 64'(m1_success_seen), 64'b0010);
        chk("m0.still_running", 64'(running), 64'd1);
        chk("m0.seen", 64'(success_seen), 64'b0010);
        frozen = cycle_count;
        chk("m0.count", frozen, 64'd5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/test_status_controller.md
Name: test_status_controller

Overview:
Synthesizable, parametrised successor to the simulation test driver's pass/fail logic. Sequences the DUT reset for a fixed number of cycles, then counts run cycles. Monitors N independent success/failure channels with a per-channel mask and resolves a single terminal PASS or FAIL verdict, including a reason code. Instantiated in the test harness and on-chip self-test wrappers, so verdicts no longer depend on testbench-only code.

Parameters:
NUM_CHANNELS, 4, number of monitored success/failure channel pairs (1..32)
CYCLE_W, 64, width of cycle counter and max_cycles
RESET_CYCLES, 16, cycles dut_reset is held after controller reset releases (>=1)
SUCCESS_MODE, 0, 0 = all masked channels must have reported success; 1 = any masked channel succeeding passes

Ports:
clock  in  1  controller clock
reset  in  1  synchronous, active-high controller reset
max_cycles  in  CYCLE_W  run-cycle limit; 0 disables the timeout; latched on HOLD->RUN
chan_mask  in  NUM_CHANNELS  1 = channel participates; latched on HOLD->RUN
chan_success  in  NUM_CHANNELS  per-channel success level, sampled every RUN cycle
chan_failure  in  NUM_CHANNELS  per-channel failure level, sampled every RUN cycle
dut_reset  out  1  reset driven to the DUT
running  out  1  high in RUN
done  out  1  high in PASS or FAIL
passed  out  1  high in PASS only
fail_reason  out  2  0 none, 1 timeout, 2 channel failure, 3 empty mask
fail_channel  out  max(1,$clog2(NUM_CHANNELS))  lowest-index failing channel (reason 2), else 0
success_seen  out  NUM_CHANNELS  sticky per-channel success record
cycle_count  out  CYCLE_W  completed RUN cycles

Behaviour:
- All outputs registered. State: HOLD, RUN, PASS, FAIL.
- Reset values: state HOLD. dut_reset=1, running=0, done=0, passed=0, fail_reason=0, fail_channel=0, success_seen=0, cycle_count=0, hold counter=0.
- Reset asserted in any state, including mid-RUN or terminal: next edge returns to the reset values.
- HOLD:
  - Hold counter increments each cycle.
  - At hold counter == RESET_CYCLES-1, latch max_cycles and chan_mask.
  - If chan_mask == 0: go to FAIL, reason 3. Otherwise go to RUN.
  - dut_reset is therefore high for exactly RESET_CYCLES cycles after reset releases.
- RUN:
  - dut_reset=0, running=1.
  - cycle_count shows 0 in the first RUN cycle and increments by 1 per cycle. It saturates at all-ones and never wraps.
  - success_seen |= chan_success & mask each cycle.
  - Evaluation each cycle, highest priority first:
    1. Any masked chan_failure: FAIL, reason 2, fail_channel = lowest set index.
    2. Success condition met: PASS. Mode 0 condition is ((success_seen | chan_success) & mask) == mask. Mode 1 condition is |(chan_success & mask).
    3. max_lat != 0 and cycle_count + 1 >= max_lat: FAIL, reason 1. A timeout therefore fires after exactly max_lat RUN cycles.
  - Same-cycle failure and success: FAIL wins. Same-cycle success and timeout: PASS wins.
- Unmasked channels are fully ignored: they have no effect on the verdict and their success_seen bits stay 0.
- PASS/FAIL are terminal until reset:
  - done=1, running=0, dut_reset=1 (DUT re-held).
  - cycle_count, success_seen, fail_reason and fail_channel are frozen.
  - Inputs are ignored.
  - In PASS, passed=1 and fail_reason=0.
- Latency: an input sampled at RUN edge N is reflected in done/passed/fail_* immediately after edge N (one register stage).

Optional Feature:
TEST_STATUS_HEARTBEAT_EN
- Defined:
  - Adds parameter HEARTBEAT_LOG2 (default 10, range 1..CYCLE_W-1) and output heartbeat (1 bit, reset 0).
  - heartbeat pulses high for one cycle in RUN whenever cycle_count[HEARTBEAT_LOG2-1:0] is all-ones.
  - It is low in HOLD, PASS and FAIL.
- Undefined: parameter and port are absent; all other behaviour is identical.

Test Plan:
- RESET_CYCLES=16, mask=4'b1111, max=0, mode 0; channels 0,1,2,3 assert success in RUN cycles 3,5,7,9 (single-cycle pulses) -> dut_reset high for exactly 16 cycles; PASS after cycle 9 edge; cycle_count=9; success_seen=4'b1111; dut_reset=1 again.
- mask=4'b0101, max=100; channel 2 fails at RUN cycle 20 while channel 1 (unmasked) fails at cycle 10 -> FAIL reason 2, fail_channel=2, cycle_count=20.
- max=50, no success -> FAIL reason 1 with cycle_count=49, done rising after the 50th RUN cycle; max=0 with no events -> stays RUN for 10000 cycles.
- Simultaneous: channel 0 success and channel 3 failure in the same cycle (mask 4'b1001) -> FAIL reason 2, fail_channel=3. Success on the final permitted cycle (cycle 49 with max=50) -> PASS.
- mask=0 at end of HOLD -> FAIL reason 3, running never asserted. Mode 1 with mask=4'b0110 and chan_success[1] at cycle 4 -> PASS at cycle 4.
- Reset asserted at RUN cycle 30 and after PASS -> all outputs return to reset values next edge, and the HOLD sequence restarts. With TEST_STATUS_HEARTBEAT_EN and HEARTBEAT_LOG2=4: heartbeat pulses at cycle_count 15, 31, 47.
